// File: rtl/lcd_pkg.sv
// Shared constants and types for the lcd_* display blocks.
// Word format, arbiter state encoding and RGB565 colours.
package lcd_pkg;

  localparam int   LCD_DW  = 9;
  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [4:0] ARB_IDLE  = 5'b00001;
  localparam logic [4:0] ARB_ISSUE = 5'b00010;
  localparam logic [4:0] ARB_WAIT  = 5'b00100;
  localparam logic [4:0] ARB_GAP   = 5'b01000;
  localparam logic [4:0] ARB_HOLD  = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE  = ARB_IDLE,
    ST_ISSUE = ARB_ISSUE,
    ST_WAIT  = ARB_WAIT,
    ST_GAP   = ARB_GAP,
    ST_HOLD  = ARB_HOLD
  } arb_state_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] val;
  } lcd_word_t;

  localparam logic [15:0] RGB_BLACK   = 16'h0000;
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_GRAY    = 16'h8410;

  function automatic logic [LCD_DW-1:0] lcd_cmd(
    input logic [7:0] b
  );
    return {DC_CMD, b};
  endfunction

  function automatic logic [LCD_DW-1:0] lcd_dat(
    input logic [7:0] b
  );
    return {DC_DATA, b};
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// Combinational round-robin select: first request at or after ptr.
// Generic, shared by any bus arbiter in the display path.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  int idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the single lcd_write engine between the lcd_* sources.
// Owner keeps the bus for a whole sequence until it releases.
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int          NUM_REQ = 3,
  parameter int          DATA_W  = 9,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [NUM_REQ-1:0]        req_en,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_release,
  output logic [NUM_REQ-1:0]        req_wr_done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      lcd_en_write,
  output logic [DATA_W-1:0]         lcd_data,
  input  logic                      lcd_wr_done,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state;
  logic [PW-1:0]       ptr;
  logic [15:0]         wd;
  logic                rel_pend;

  logic [NUM_REQ-1:0]  pick;
  logic                pick_vld;
  logic [PW-1:0]       pick_idx;
  logic [PW-1:0]       ptr_nxt;
  logic [DATA_W-1:0]   own_word;
  logic                own_req;
  logic                own_rel;
  logic                wd_exp;
  logic                wr_end;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req   (req_en),
    .ptr   (ptr),
    .gnt   (pick),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  assign ptr_nxt = (pick_idx == PW'(NUM_REQ - 1)) ?
                   '0 : pick_idx + 1'b1;

  always_comb begin
    own_word = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) own_word = own_word | req_data[i*DATA_W +: DATA_W];
  end

  assign own_req = |(req_en & grant);
  assign own_rel = |(req_release & grant);
  assign wd_exp  = (wd == TIMEOUT - 16'd1);

  // Completion (or abort) goes straight back to the owner, no extra flop.
  assign wr_end      = (state == ST_WAIT) && (lcd_wr_done || wd_exp);
  assign req_wr_done = wr_end ? grant : '0;
  assign busy        = |grant;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      grant        <= '0;
      ptr          <= '0;
      wd           <= '0;
      rel_pend     <= 1'b0;
      lcd_en_write <= 1'b0;
      lcd_data     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      lcd_en_write <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            grant    <= pick;
            ptr      <= ptr_nxt;
            rel_pend <= 1'b0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lcd_data     <= own_word;
          lcd_en_write <= 1'b1;
          wd           <= '0;
          rel_pend     <= rel_pend | own_rel;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          rel_pend <= rel_pend | own_rel;
          if (lcd_wr_done) begin
            state <= ST_GAP;
          end else if (wd_exp) begin
            timeout_err <= 1'b1;
            state       <= ST_GAP;
          end else begin
            wd <= wd + 16'd1;
          end
        end
        // Owner still holds req_en here for the word just finished.
        ST_GAP: begin
          if (rel_pend || own_rel) begin
            grant    <= '0;
            rel_pend <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (own_rel) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (own_req) begin
            state <= ST_ISSUE;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter.
// Directed requester threads, lcd_write responder model, event monitor.
`timescale 1ns/1ps
module tb_lcd_write_arbiter;

  localparam int N  = 3;
  localparam int DW = 9;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_en;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_release;
  logic [N-1:0]    req_wr_done;
  logic [N-1:0]    grant;
  logic            lcd_en_write;
  logic [DW-1:0]   lcd_data;
  logic            lcd_wr_done;
  logic            busy;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_data[$];
  logic [N:0]    exp_done[$];
  logic [DW-1:0] words [N][8];
  logic [N:0]    mon_e;
  logic [N-1:0]  prev_grant;

  int resp_dly     = 3;
  bit no_resp      = 1'b0;
  int own2_strobes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (DW),
    .TIMEOUT (16'd100)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .req_en       (req_en),
    .req_data     (req_data),
    .req_release  (req_release),
    .req_wr_done  (req_wr_done),
    .grant        (grant),
    .lcd_en_write (lcd_en_write),
    .lcd_data     (lcd_data),
    .lcd_wr_done  (lcd_wr_done),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (grant !== prev_grant) begin
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("busy_vs_grant", 32'(busy), 32'(|grant));
      end
      prev_grant = grant;
      if (lcd_en_write) begin
        if (grant == 3'b100) own2_strobes++;
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_unexpected: got data %0h expected none",
                   lcd_data);
        end else begin
          chk("lcd_data", 32'(lcd_data), 32'(exp_data.pop_front()));
        end
      end
      if (req_wr_done != '0) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_done_unexpected: got %0b expected none",
                   req_wr_done);
        end else begin
          mon_e = exp_done.pop_front();
          chk("wr_done_owner", 32'(req_wr_done), 32'(mon_e[N-1:0]));
          chk("wr_done_src", 32'(lcd_wr_done), 32'(mon_e[N]));
        end
      end
    end else begin
      prev_grant = '0;
    end
  end

  // lcd_write model: one completion pulse resp_dly cycles after strobe.
  initial begin
    lcd_wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && lcd_en_write && !no_resp) begin
        repeat (resp_dly) @(posedge clk);
        #1 lcd_wr_done = 1'b1;
        @(posedge clk);
        #1 lcd_wr_done = 1'b0;
      end
    end
  end

  // Source model: level request held one cycle past wr_done, then release.
  task automatic run_req(input int i, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      req_data[i*DW +: DW] = words[i][k];
      req_en[i] = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_wr_done[i] && t < 1000) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("wait_done_r%0d_w%0d", i, k),
          32'(req_wr_done[i]), 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      if (k == n - 1) req_en[i] = 1'b0;
    end
    req_release[i] = 1'b1;
    @(posedge clk);
    #1 req_release[i] = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_en_write"}, 32'(lcd_en_write), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_done"}, 32'(req_wr_done), 32'd0);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    req_en      = '0;
    req_release = '0;
    req_data    = '0;
    #1 chk_reset_state("rst");
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    checks++;
    errors++;
    $display("FAIL global_time_limit: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n       = 1'b0;
    req_en      = '0;
    req_release = '0;
    req_data    = '0;
    prev_grant  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("por");
    chk("por_lcd_data", 32'(lcd_data), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester, slow writer.
    @(posedge clk);
    #1;
    resp_dly = 20;
    words[2][0] = 9'h02C;
    exp_data.push_back(9'h02C);
    exp_done.push_back(4'b1100);
    fork
      run_req(2, 1);
      begin
        @(negedge clk);
        chk("t1_grant_c0", 32'(grant), 32'd0);
        @(negedge clk);
        chk("t1_grant_c1", 32'(grant), 32'b100);
        @(negedge clk);
        chk("t1_strobe_c2", 32'(lcd_en_write), 32'd1);
      end
    join

    // Contention from reset: owners 0, 1, 2 in order.
    do_reset();
    @(posedge clk);
    #1;
    resp_dly = 3;
    words[0][0] = 9'h02A;
    words[1][0] = 9'h133;
    words[2][0] = 9'h0C5;
    exp_data.push_back(9'h02A);
    exp_data.push_back(9'h133);
    exp_data.push_back(9'h0C5);
    exp_done.push_back(4'b1001);
    exp_done.push_back(4'b1010);
    exp_done.push_back(4'b1100);
    fork
      run_req(0, 1);
      run_req(1, 1);
      run_req(2, 1);
    join

    // Locked ownership: owner 2 streams while requester 1 waits.
    @(posedge clk);
    #1;
    words[2][0] = 9'h1F8;
    words[2][1] = 9'h100;
    words[2][2] = 9'h107;
    words[2][3] = 9'h0E0;
    words[1][0] = 9'h155;
    exp_data.push_back(9'h1F8);
    exp_data.push_back(9'h100);
    exp_data.push_back(9'h107);
    exp_data.push_back(9'h0E0);
    exp_data.push_back(9'h155);
    for (int k = 0; k < 4; k++) exp_done.push_back(4'b1100);
    exp_done.push_back(4'b1010);
    own2_strobes = 0;
    fork
      run_req(2, 4);
      begin
        int t3;
        t3 = 0;
        @(negedge clk);
        while (grant !== 3'b100 && t3 < 50) begin
          @(negedge clk);
          t3++;
        end
        chk("t3_owner2", 32'(grant), 32'b100);
        @(posedge clk);
        #1;
        run_req(1, 1);
      end
    join
    chk("t3_owner2_strobes", 32'(own2_strobes), 32'd4);

    // Watchdog abort: writer never answers.
    @(posedge clk);
    #1;
    no_resp = 1'b1;
    words[0][0] = 9'h0AA;
    words[0][1] = 9'h1BB;
    exp_data.push_back(9'h0AA);
    exp_data.push_back(9'h1BB);
    exp_done.push_back(4'b0001);
    exp_done.push_back(4'b0001);
    fork
      run_req(0, 2);
      begin
        int t4;
        t4 = 0;
        @(negedge clk);
        while (!lcd_en_write && t4 < 20) begin
          @(negedge clk);
          t4++;
        end
        chk("t4_strobe", 32'(lcd_en_write), 32'd1);
        repeat (99) @(negedge clk);
        chk("t4_err_before", 32'(timeout_err), 32'd0);
        chk("t4_abort_done", 32'(req_wr_done), 32'b001);
        @(negedge clk);
        chk("t4_err_set", 32'(timeout_err), 32'd1);
      end
    join

    // Reset in WAIT, then arbitration restarts at index 0.
    @(posedge clk);
    #1;
    req_data[0 +: DW] = 9'h03C;
    req_en = 3'b001;
    exp_data.push_back(9'h03C);
    begin
      int t5;
      t5 = 0;
      @(negedge clk);
      while (!lcd_en_write && t5 < 20) begin
        @(negedge clk);
        t5++;
      end
      chk("t5_strobe", 32'(lcd_en_write), 32'd1);
    end
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    req_en = '0;
    #1 chk_reset_state("t5_async");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    no_resp = 1'b0;
    @(posedge clk);
    #1;
    words[0][0] = 9'h0D1;
    words[1][0] = 9'h0E2;
    exp_data.push_back(9'h0D1);
    exp_data.push_back(9'h0E2);
    exp_done.push_back(4'b1001);
    exp_done.push_back(4'b1010);
    fork
      run_req(0, 1);
      run_req(1, 1);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t5_rearb_idx0", 32'(grant), 32'b001);
      end
    join

    repeat (5) @(posedge clk);
    chk("sb_data_empty", 32'(exp_data.size()), 32'd0);
    chk("sb_done_empty", 32'(exp_done.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
